// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester/register-side bundle of the shared-register arbiter
interface dff_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int OW = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0] gnt;
  logic ack;
  logic [WIDTH-1:0] Q;
  logic [OW-1:0] owner;
  logic [15:0] wr_count;
  modport master (output req, wdata, input gnt, ack, Q, owner, wr_count);
  modport slave (input req, wdata, output gnt, ack, Q, owner, wr_count);
endinterface

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter owning a shared register, closed by a four-phase req/ack
module dff_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int OW = $clog2(N_REQ)
) (
  input logic clk,
  input logic reset,
  dff_bank_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [OW-1:0] ptr, ptr_n, win, win_n, pick, owner_r, owner_n;
  logic [N_REQ-1:0] gnt_r, gnt_n;
  logic ack_r, ack_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [15:0] cnt, cnt_n;
  int idx;
  always_comb begin
    pick = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (bus.req[idx]) pick = OW'(idx);
    end
  end
  always_comb begin
    state_n = state;
    win_n = win;
    gnt_n = '0;
    ack_n = ack_r;
    q_n = q_r;
    owner_n = owner_r;
    ptr_n = ptr;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        ack_n = 1'b0;
        if (|bus.req) begin
          win_n = pick;
          gnt_n = N_REQ'(1) << pick;
          state_n = GRANT;
        end
      end
      GRANT: begin
        q_n = bus.wdata[win*WIDTH +: WIDTH];
        owner_n = win;
        ptr_n = (win == OW'(N_REQ - 1)) ? '0 : win + OW'(1);
        cnt_n = &cnt ? cnt : cnt + 16'd1;
        ack_n = 1'b1;
        state_n = RELEASE;
      end
      RELEASE: begin
        ack_n = bus.req[win];
        state_n = bus.req[win] ? RELEASE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= !reset ? IDLE : state_n;
    win <= !reset ? '0 : win_n;
    ptr <= !reset ? '0 : ptr_n;
    gnt_r <= !reset ? '0 : gnt_n;
    ack_r <= !reset ? 1'b0 : ack_n;
    q_r <= !reset ? '0 : q_n;
    owner_r <= !reset ? '0 : owner_n;
    cnt <= !reset ? '0 : cnt_n;
  end
  assign bus.gnt = gnt_r;
  assign bus.ack = ack_r;
  assign bus.Q = q_r;
  assign bus.owner = owner_r;
  assign bus.wr_count = cnt;
endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit D flip-flop register. Up to N_REQ requesters compete for write access. The block grants one requester at a time and loads that requester's data into the shared register. It closes each transfer with a four-phase req/ack handshake. It sits between requester logic and the shared register, and it owns the register.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- WIDTH, 8: width of the shared register and of each data slice.
- OW, $clog2(N_REQ): width of `owner`. Derived; do not override.

- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  in  N_REQ  request bits; req[i] is held by requester i until ack is seen.
- wdata  in  N_REQ*WIDTH  write data; requester i drives bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant; high for exactly one cycle per transfer.
- ack  out  1  transfer complete; high throughout RELEASE.
- Q  out  WIDTH  shared register contents.
- owner  out  OW  index of the last requester written.
- wr_count  out  16  number of completed writes; saturates at 16'hFFFF.

## Operation
- All outputs are registered.
- Reset values: Q=0, gnt=0, ack=0, owner=0, wr_count=0, state=IDLE, ptr=0.
- Reset overrides every other event on the same edge, including mid-transfer. No write completes on an edge where reset=0.
- ptr is the highest-priority index.
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, … mod N_REQ.
- States:
  - IDLE: gnt=0, ack=0.
    - If req≠0 at an edge: latch the winner into win, set gnt[win]=1, go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT: gnt[win]=1 for this one cycle only. At the closing edge:
    - Q ← wdata slice win, sampled at that edge.
    - owner ← win.
    - ptr ← (win+1) mod N_REQ.
    - wr_count ← wr_count+1, saturating.
    - gnt ← 0, ack ← 1, go to RELEASE.
  - RELEASE: ack=1. Stay while req[win]=1; at the first edge with req[win]=0, ack ← 0 and go to IDLE.
- Requests are not queued. Any requester still requesting re-competes in IDLE.
- Requests from non-winners during GRANT or RELEASE are ignored until IDLE.
- req[win] dropping during GRANT: the write still happens and ack still pulses. RELEASE then exits on the next edge.
- wdata of non-granted requesters never affects Q.
- Q is stable at all times outside the single GRANT→RELEASE edge.
- Fairness: after requester i is served, every other requester that is continuously requesting is served before i is served again.

## Timing
- req[i] rises before edge E0 with the block in IDLE:
  - gnt[i]=1 after E0.
  - Q updated and ack=1 after E0+1.
- Minimum ack duration is one cycle.
- req drops before edge Ek: ack=0 and state=IDLE after Ek.
- Earliest next grant is after Ek+1.
- Minimum transfer period is 3 cycles: IDLE, GRANT, RELEASE with the requester dropping req in the same cycle ack rises.
- gnt and ack are never high in the same cycle.
- gnt is always one-hot or zero.

## Test plan
- Reset mid-transfer: set Q=8'h5A, then assert req[2] and pull reset low during GRANT → after that edge Q=0, gnt=0, ack=0, owner=0, wr_count=0. After reset is released, a fresh req[2] completes normally.
- Single requester: req=4'b0100, wdata slice 2=8'hC3 → gnt=4'b0100 for one cycle, then Q=8'hC3, owner=2, ack high until req[2] falls, wr_count=1.
- Round-robin under contention: req=4'b1111 held with immediate release after each ack, slice i=8'h10+i → grants in order 0,1,2,3,0; Q sequence 10,11,12,13,10.
- Pointer skip: ptr=3 after serving 2, then req=4'b0011 → winner 0, then 1; requester 3 is not granted.
- Withdrawal during GRANT: req[1] drops in the GRANT cycle, wdata slice 1=8'h77 → Q=8'h77, ack high for exactly one cycle, IDLE on the next edge.
- Hold in RELEASE: winner holds req for 5 cycles while req[0] is asserted → ack stays high 5 cycles, gnt stays 0, and req[0] is granted only after IDLE. Drive with wr_count preloaded near saturation → wr_count stays at 16'hFFFF after saturating.
